cnn_layer_sequencer: RTL and testbench

Sequences a multi-layer CNN run once the CPU has finished configuring the engine. It watches the 2-bit setting-done condition and launches each layer in turn with a one-cycle start pulse, then waits for the engine's layer-done strobe. When the last layer completes, or on abort, it clears the condition with a single write-back. It sits between the CPU-written setting-done register and the CNN layer engine, and raises a done flag for the interrupt path.

---
 rtl/cnn_layer_sequencer.sv | 154 +++++++++++++++
 tb/tb_cnn_layer_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_layer_sequencer.sv
// CNN layer sequencer: launches each layer, waits for done, clears setting-done.
// Define CNN_SEQ_PERF_EN to build the run_cycles performance counter.
module cnn_layer_sequencer #(
  parameter int NUM_LAYERS = 4,
  parameter int LAYER_W    = 2,
  parameter int GAP_CYCLES = 2,
  parameter int CNT_W      = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         setting_done_condition,
  input  logic               layer_done,
  input  logic               abort,
  input  logic               done_ack,
  output logic               layer_start,
  output logic [LAYER_W-1:0] layer_idx,
  output logic               busy,
  output logic               cnn_done,
  output logic               set_write_signal,
  output logic [1:0]         set_write_data,
  output logic [CNT_W-1:0]   run_cycles
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [LAYER_W-1:0] LAST = LAYER_W'(NUM_LAYERS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_GAP,
    S_CLEAR,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [LAYER_W-1:0] idx_q, idx_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic               abrt_q, abrt_d;
  logic               start_q, busy_q, done_q, wr_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    abrt_d  = abrt_q;
    unique case (state_q)
      S_IDLE: begin
        if (setting_done_condition == 2'b11 && !abort) begin
          state_d = S_START;
          idx_d   = '0;
          abrt_d  = 1'b0;
        end
      end
      S_START: begin
        if (abort) begin
          state_d = S_CLEAR;
          abrt_d  = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort) begin
          state_d = S_CLEAR;
          abrt_d  = 1'b1;
        end else if (layer_done) begin
          if (idx_q == LAST) begin
            state_d = S_CLEAR;
          end else if (GAP_CYCLES == 0) begin
            state_d = S_START;
            idx_d   = idx_q + LAYER_W'(1);
          end else begin
            state_d = S_GAP;
            gap_d   = GW'(GAP_LOAD);
          end
        end
      end
      S_GAP: begin
        if (abort) begin
          state_d = S_CLEAR;
          abrt_d  = 1'b1;
        end else if (gap_q == '0) begin
          state_d = S_START;
          idx_d   = idx_q + LAYER_W'(1);
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      S_CLEAR: begin
        state_d = abrt_q ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        if (done_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered copies of the next-state decode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      gap_q   <= '0;
      abrt_q  <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      abrt_q  <= abrt_d;
      start_q <= (state_d == S_START);
      busy_q  <= (state_d != S_IDLE) && (state_d != S_DONE);
      done_q  <= (state_d == S_DONE);
      wr_q    <= (state_d == S_CLEAR);
    end
  end

  assign layer_start      = start_q;
  assign layer_idx        = idx_q;
  assign busy             = busy_q;
  assign cnn_done         = done_q;
  assign set_write_signal = wr_q;
  assign set_write_data   = 2'b00;

`ifdef CNN_SEQ_PERF_EN
  logic [CNT_W-1:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if (state_q == S_IDLE && state_d == S_START) begin
      cyc_d = '0;
    end else if (state_q != S_IDLE && state_q != S_DONE &&
                 cyc_q != '1) begin
      cyc_d = cyc_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cyc_q <= '0;
    else      cyc_q <= cyc_d;
  end

  assign run_cycles = cyc_q;
`else
  assign run_cycles = '0;
`endif

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Scoreboard bench for cnn_layer_sequencer: three configurations,
// directed runs, expected events queued by the driver, checked by a monitor.
module tb_cnn_layer_sequencer;

`ifdef CNN_SEQ_PERF_EN
  localparam int RC_EXP = 7;
`else
  localparam int RC_EXP = 0;
`endif

  localparam int K_START = 0;
  localparam int K_WRITE = 1;
  localparam int K_DONE  = 2;

  typedef struct {
    int dut;
    int kind;
    int idx;
    int cyc;
  } ev_t;

  logic        clk;
  logic        rst_n;
  logic [1:0]  cond [3];
  logic        ld   [3];
  logic        ab   [3];
  logic        ack  [3];
  logic        st   [3];
  logic        bsy  [3];
  logic        dn   [3];
  logic        wr   [3];
  logic [1:0]  idx  [3];
  logic [1:0]  wd   [3];
  logic [31:0] rc   [3];
  logic        dn_prev [3];

  ev_t sb[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cnn_layer_sequencer #(.NUM_LAYERS(4), .LAYER_W(2), .GAP_CYCLES(2),
    .CNT_W(32)) u_a (
    .clk(clk), .rst(rst_n),
    .setting_done_condition(cond[0]), .layer_done(ld[0]),
    .abort(ab[0]), .done_ack(ack[0]),
    .layer_start(st[0]), .layer_idx(idx[0]), .busy(bsy[0]),
    .cnn_done(dn[0]), .set_write_signal(wr[0]),
    .set_write_data(wd[0]), .run_cycles(rc[0]));

  cnn_layer_sequencer #(.NUM_LAYERS(2), .LAYER_W(2), .GAP_CYCLES(0),
    .CNT_W(32)) u_b (
    .clk(clk), .rst(rst_n),
    .setting_done_condition(cond[1]), .layer_done(ld[1]),
    .abort(ab[1]), .done_ack(ack[1]),
    .layer_start(st[1]), .layer_idx(idx[1]), .busy(bsy[1]),
    .cnn_done(dn[1]), .set_write_signal(wr[1]),
    .set_write_data(wd[1]), .run_cycles(rc[1]));

  cnn_layer_sequencer #(.NUM_LAYERS(1), .LAYER_W(2), .GAP_CYCLES(2),
    .CNT_W(32)) u_c (
    .clk(clk), .rst(rst_n),
    .setting_done_condition(cond[2]), .layer_done(ld[2]),
    .abort(ab[2]), .done_ack(ack[2]),
    .layer_start(st[2]), .layer_idx(idx[2]), .busy(bsy[2]),
    .cnn_done(dn[2]), .set_write_signal(wr[2]),
    .set_write_data(wd[2]), .run_cycles(rc[2]));

  task automatic push(int d, int k, int i, int c);
    ev_t e;
    e.dut = d; e.kind = k; e.idx = i; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_ev(int d, int k, int i);
    ev_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL ev_unexpected: got dut%0d kind%0d at cyc %0d, expected none",
               d, k, cyc);
    end else begin
      e = sb.pop_front();
      if (e.dut != d || e.kind != k || e.idx != i || e.cyc != cyc) begin
        errors++;
        $display("FAIL ev dut/kind/idx/cyc: got %0d/%0d/%0d/%0d, expected %0d/%0d/%0d/%0d",
                 d, k, i, cyc, e.dut, e.kind, e.idx, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rst_n) begin
        if (st[d]) chk_ev(d, K_START, int'(idx[d]));
        if (wr[d]) begin
          chk_ev(d, K_WRITE, 0);
          chk("write_data", 32'(wd[d]), 32'd0);
        end
        if (dn[d] && !dn_prev[d]) chk_ev(d, K_DONE, 0);
      end
      dn_prev[d] = dn[d];
    end
  end

  task automatic wait_cyc(int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic pulse_ld(int d);
    ld[d] = 1'b1;
    @(negedge clk);
    ld[d] = 1'b0;
  endtask

  task automatic trigger(int d, output int s);
    cond[d] = 2'b11;
    s = cyc + 1;
    push(d, K_START, 0, s);
    @(negedge clk);
    cond[d] = 2'b00;
  endtask

  initial begin
    int s;
    int dd;
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      cond[d] = 2'b00; ld[d] = 1'b0; ab[d] = 1'b0; ack[d] = 1'b0;
      dn_prev[d] = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    chk("rst_start", 32'(st[0]), 0);
    chk("rst_busy", 32'(bsy[0]), 0);
    chk("rst_done", 32'(dn[0]), 0);
    chk("rst_write", 32'(wr[0]), 0);
    chk("rst_idx", 32'(idx[0]), 0);
    chk("rst_cycles", rc[0], 0);
    rst_n = 1'b1;

    // partial conditions never start
    cond[0] = 2'b01;
    repeat (10) @(negedge clk);
    chk("cond01_busy", 32'(bsy[0]), 0);
    cond[0] = 2'b10;
    repeat (10) @(negedge clk);
    chk("cond10_busy", 32'(bsy[0]), 0);
    cond[0] = 2'b00;
    @(negedge clk);

    // full 4-layer run, gap 2, three WAIT cycles per layer
    trigger(0, s);
    for (int i = 0; i < 4; i++) begin
      wait_cyc(s + 3);
      if (i == 1) chk("run_busy", 32'(bsy[0]), 1);
      if (i < 3) begin
        push(0, K_START, i + 1, s + 6);
      end else begin
        push(0, K_WRITE, 0, s + 4);
        push(0, K_DONE, 0, s + 5);
      end
      pulse_ld(0);
      if (i < 3) s = s + 6;
    end
    dd = s + 5;
    wait_cyc(dd + 3);
    chk("done_held", 32'(dn[0]), 1);
    chk("done_busy", 32'(bsy[0]), 0);
    chk("last_idx", 32'(idx[0]), 3);
    ack[0] = 1'b1;
    @(negedge clk);
    ack[0] = 1'b0;
    chk("ack_done", 32'(dn[0]), 0);
    repeat (4) @(negedge clk);
    chk("ack_idle_busy", 32'(bsy[0]), 0);

    // zero-gap config starts next layer right after layer_done
    trigger(1, s);
    wait_cyc(s + 2);
    push(1, K_START, 1, s + 3);
    pulse_ld(1);
    s = s + 3;
    wait_cyc(s + 2);
    push(1, K_WRITE, 0, s + 3);
    push(1, K_DONE, 0, s + 4);
    pulse_ld(1);
    wait_cyc(s + 5);
    ack[1] = 1'b1;
    @(negedge clk);
    ack[1] = 1'b0;
    @(negedge clk);
    chk("b_idle_done", 32'(dn[1]), 0);

    // abort held in IDLE blocks a start
    cond[0] = 2'b11;
    ab[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_idle_busy", 32'(bsy[0]), 0);
    cond[0] = 2'b00;
    ab[0] = 1'b0;
    @(negedge clk);

    // abort together with layer_done in WAIT of layer 1
    trigger(0, s);
    wait_cyc(s + 3);
    push(0, K_START, 1, s + 6);
    pulse_ld(0);
    s = s + 6;
    wait_cyc(s + 2);
    push(0, K_WRITE, 0, s + 3);
    ld[0] = 1'b1;
    ab[0] = 1'b1;
    @(negedge clk);
    ld[0] = 1'b0;
    ab[0] = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_done", 32'(dn[0]), 0);
    chk("abort_busy", 32'(bsy[0]), 0);

    // reset asserted while in GAP
    trigger(0, s);
    wait_cyc(s + 3);
    pulse_ld(0);
    chk("gap_busy", 32'(bsy[0]), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(bsy[0]), 0);
    chk("mid_rst_idx", 32'(idx[0]), 0);
    chk("mid_rst_start", 32'(st[0]), 0);
    chk("mid_rst_write", 32'(wr[0]), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_rst_busy", 32'(bsy[0]), 0);

    // single-layer run, five WAIT cycles, run_cycles check
    trigger(2, s);
    wait_cyc(s + 5);
    push(2, K_WRITE, 0, s + 6);
    push(2, K_DONE, 0, s + 7);
    pulse_ld(2);
    wait_cyc(s + 8);
    chk("run_cycles_done", rc[2], 32'(RC_EXP));
    ack[2] = 1'b1;
    @(negedge clk);
    ack[2] = 1'b0;
    repeat (3) @(negedge clk);
    chk("run_cycles_idle", rc[2], 32'(RC_EXP));

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
